// File: rtl/player_position_pkg.sv
// Shared video-block constants: line geometry, NUSIZ copy codes, HMOVE states.
// Imported by the player and missile position counters.
package player_position_pkg;

    localparam int DEF_LINE_WIDTH = 160;
    localparam int DEF_POS_BITS   = 8;

    // Copy offsets from the main copy, in pixel clocks
    localparam int OFS_CLOSE  = 16;
    localparam int OFS_MEDIUM = 32;
    localparam int OFS_WIDE   = 64;

    localparam logic [2:0] NUSIZ_ONE         = 3'b000;
    localparam logic [2:0] NUSIZ_TWO_CLOSE   = 3'b001;
    localparam logic [2:0] NUSIZ_TWO_MEDIUM  = 3'b010;
    localparam logic [2:0] NUSIZ_THREE_CLOSE = 3'b011;
    localparam logic [2:0] NUSIZ_TWO_WIDE    = 3'b100;
    localparam logic [2:0] NUSIZ_DOUBLE      = 3'b101;
    localparam logic [2:0] NUSIZ_THREE_MED   = 3'b110;
    localparam logic [2:0] NUSIZ_QUAD        = 3'b111;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ADVANCE = 2'd1,
        HOLD    = 2'd2
    } hm_state_t;

    // Magnitude of a 4-bit two's-complement motion value; -8 yields 8
    function automatic logic [3:0] motion_mag(input logic [3:0] m);
        return m[3] ? (~m + 4'd1) : m;
    endfunction

endpackage

// File: rtl/player_position_match.sv
// Combinational NUSIZ copy decoder: flags counter values that start a copy.
// Shared by the player and missile position counters.
module copy_match
    import player_position_pkg::*;
#(
    parameter int POS_BITS = DEF_POS_BITS
) (
    input  logic [POS_BITS-1:0] counter,
    input  logic [2:0]          copies,
    output logic                match
);

    logic at_main;
    logic at_close;
    logic at_medium;
    logic at_wide;

    assign at_main   = (counter == '0);
    assign at_close  = (counter == POS_BITS'(OFS_CLOSE));
    assign at_medium = (counter == POS_BITS'(OFS_MEDIUM));
    assign at_wide   = (counter == POS_BITS'(OFS_WIDE));

    always_comb begin
        match = at_main;
        case (copies)
            NUSIZ_TWO_CLOSE:   match = at_main | at_close;
            NUSIZ_TWO_MEDIUM:  match = at_main | at_medium;
            NUSIZ_THREE_CLOSE: match = at_main | at_close | at_medium;
            NUSIZ_TWO_WIDE:    match = at_main | at_wide;
            NUSIZ_THREE_MED:   match = at_main | at_medium | at_wide;
            default:           match = at_main;
        endcase
    end

endmodule

// File: rtl/player_position.sv
// Player horizontal position counter with RESPx reset, HMOVE fine motion
// and NUSIZ copy start strobes for the sprite serializer.
module player_position
    import player_position_pkg::*;
#(
    parameter int LINE_WIDTH = DEF_LINE_WIDTH,
    parameter int POS_BITS   = DEF_POS_BITS
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                hblank,
    input  logic                resp,
    input  logic                motion_write,
    input  logic [3:0]          motion_data,
    input  logic                motion_clear,
    input  logic                hmove,
    input  logic [2:0]          copies,
    output logic                strobe,
    output logic [POS_BITS-1:0] position,
    output logic                moving
);

    localparam logic [POS_BITS-1:0] LAST = POS_BITS'(LINE_WIDTH - 1);

    hm_state_t           state;
    hm_state_t           state_n;
    logic [3:0]          remaining;
    logic [3:0]          remaining_n;
    logic [3:0]          motion;
    logic [POS_BITS-1:0] counter;
    logic [POS_BITS-1:0] counter_n;
    logic [POS_BITS-1:0] counter_inc;
    logic                tick;
    logic                match;
    logic                strobe_n;

    assign counter_inc = (counter == LAST) ? '0 : counter + POS_BITS'(1);

    // ADVANCE ticks every clock; HOLD swallows the visible-line ticks
    assign tick = (state == ADVANCE) || (!hblank && state != HOLD);

    copy_match #(
        .POS_BITS(POS_BITS)
    ) u_copy_match (
        .counter(counter_inc),
        .copies (copies),
        .match  (match)
    );

    always_comb begin
        state_n     = state;
        remaining_n = remaining;
        counter_n   = counter;
        strobe_n    = 1'b0;
        if (resp) begin
            counter_n   = '0;
            state_n     = IDLE;
            remaining_n = '0;
        end else begin
            if (tick) begin
                counter_n = counter_inc;
                strobe_n  = match;
            end
            if (hmove && motion != 4'd0) begin
                state_n     = motion[3] ? HOLD : ADVANCE;
                remaining_n = motion_mag(motion);
            end else begin
                unique case (state)
                    ADVANCE: begin
                        remaining_n = remaining - 4'd1;
                        if (remaining == 4'd1) state_n = IDLE;
                    end
                    HOLD: begin
                        if (!hblank) begin
                            remaining_n = remaining - 4'd1;
                            if (remaining == 4'd1) state_n = IDLE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            remaining <= '0;
            counter   <= '0;
            strobe    <= 1'b0;
        end else begin
            state     <= state_n;
            remaining <= remaining_n;
            counter   <= counter_n;
            strobe    <= strobe_n;
        end
    end

    // Motion writes never touch an adjustment already in flight
    always_ff @(posedge clk) begin
        if (!reset) begin
            motion <= '0;
        end else if (motion_clear) begin
            motion <= '0;
        end else if (motion_write) begin
            motion <= motion_data;
        end
    end

    assign position = counter;
    assign moving   = (state != IDLE);

endmodule
